// File: rtl/fib_seq_engine_if.sv
// Start/done handshake bundle for fib_seq_engine.
// The master loads a job and the slave returns the final a.
interface fib_seq_engine_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
);
  logic             r_enable;
  logic [CNT_W-1:0] init_n;
  logic [WIDTH-1:0] init_a;
  logic [WIDTH-1:0] init_b;
  logic [1:0]       init_mode;
  logic [WIDTH-1:0] init_mod;
  logic             w_enable;
  logic             busy;
  logic             overflow;
  logic [WIDTH-1:0] result;

  modport master (
    output r_enable, init_n, init_a,
    output init_b, init_mode, init_mod,
    input  w_enable, busy, overflow, result
  );

  modport slave (
    input  r_enable, init_n, init_a,
    input  init_b, init_mode, init_mod,
    output w_enable, busy, overflow, result
  );
endinterface

// File: rtl/fib_seq_engine.sv
// Parametrised Fibonacci-step engine: (a,b) <- (b,f(a,b)) n times.
// Supports wrap, saturate and modular sums with sticky overflow.
module fib_seq_engine #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  fib_seq_engine_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       mode_q, mode_d;
  logic             we_q, we_d;
  logic             busy_q, busy_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   red;
  logic [WIDTH-1:0] f;
  logic             carry;

  // mod==0 in modular mode falls out as a plain wrap with no carry flag
  always_comb begin
    sum   = {1'b0, a_q} + {1'b0, b_q};
    red   = sum - {1'b0, mod_q};
    carry = 1'b0;
    f     = sum[WIDTH-1:0];
    unique case (1'b1)
      mode_q == 2'd1: begin
        carry = sum[WIDTH];
        f     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
      end
      mode_q == 2'd2: begin
        if (sum >= {1'b0, mod_q})
          f = red[WIDTH-1:0];
      end
      default: carry = sum[WIDTH];
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mod_d   = mod_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    we_d    = we_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    if (bus.r_enable) begin
      a_d     = bus.init_a;
      b_d     = bus.init_b;
      cnt_d   = bus.init_n;
      mode_d  = bus.init_mode;
      mod_d   = bus.init_mod;
      we_d    = 1'b0;
      ovf_d   = 1'b0;
      busy_d  = 1'b1;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (cnt_q == '0) begin
        res_d   = a_q;
        we_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end else begin
        a_d   = b_q;
        b_d   = f;
        cnt_d = cnt_q - 1'b1;
        ovf_d = ovf_q | carry;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mod_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mod_q   <= mod_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.w_enable = we_q;
  assign bus.busy     = busy_q;
  assign bus.overflow = ovf_q;
  assign bus.result   = res_q;
endmodule

// File: tb/tb_fib_seq_engine.sv
// Bench for fib_seq_engine: 32-bit and 8-bit instances,
// directed cases plus random jobs against a behavioural model.
module tb_fib_seq_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fib_seq_engine_if #(.WIDTH(32), .CNT_W(32)) i32 ();
  fib_seq_engine_if #(.WIDTH(8),  .CNT_W(32)) i8  ();

  fib_seq_engine #(.WIDTH(32), .CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .bus(i32.slave)
  );
  fib_seq_engine #(.WIDTH(8), .CNT_W(32)) dut8 (
    .clk(clk), .rst(rst), .bus(i8.slave)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void ref_model(
    input int w, input longint unsigned n,
    input longint unsigned a0, input longint unsigned b0,
    input logic [1:0] mode, input longint unsigned m,
    output longint unsigned res, output bit ovf);
    longint unsigned a, b, s, f, mask;
    mask = (64'd1 << w) - 1;
    a = a0; b = b0; ovf = 0;
    repeat (n) begin
      s = a + b;
      if (mode == 2'd2) begin
        f = ((s >= m) ? s - m : s) & mask;
      end else if (s > mask) begin
        ovf = 1;
        f = (mode == 2'd1) ? mask : (s & mask);
      end else begin
        f = s;
      end
      a = b;
      b = f;
    end
    res = a;
  endfunction

  task automatic drive(input bit w8, input bit en,
                       input logic [31:0] n, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] mode,
                       input logic [31:0] m);
    if (w8) begin
      i8.r_enable = en; i8.init_n = n;
      i8.init_a = a[7:0]; i8.init_b = b[7:0];
      i8.init_mode = mode; i8.init_mod = m[7:0];
    end else begin
      i32.r_enable = en; i32.init_n = n;
      i32.init_a = a; i32.init_b = b;
      i32.init_mode = mode; i32.init_mod = m;
    end
  endtask

  task automatic set_en(input bit w8, input bit en);
    if (w8) i8.r_enable = en;
    else    i32.r_enable = en;
  endtask

  task automatic smp(input bit w8, output logic we, output logic bz,
                     output logic ov, output logic [31:0] r);
    if (w8) begin
      we = i8.w_enable; bz = i8.busy;
      ov = i8.overflow; r = {24'd0, i8.result};
    end else begin
      we = i32.w_enable; bz = i32.busy;
      ov = i32.overflow; r = i32.result;
    end
  endtask

  // Launches a job and checks busy/w_enable timing up to done.
  task automatic run_job(input string tag, input bit w8,
                         input logic [31:0] n, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] mode,
                         input logic [31:0] m,
                         output logic [31:0] res, output logic ov);
    logic we, bz, o;
    logic [31:0] r;
    int early;
    @(negedge clk);
    drive(w8, 1'b1, n, a, b, mode, m);
    @(negedge clk);
    set_en(w8, 1'b0);
    smp(w8, we, bz, o, r);
    chk({tag, ":busy_start"}, {63'd0, bz}, 64'd1);
    early = 0;
    for (int k = 1; k <= int'(n); k++) begin
      @(negedge clk);
      smp(w8, we, bz, o, r);
      if (we || !bz) early++;
    end
    chk({tag, ":timing"}, early, 0);
    @(negedge clk);
    smp(w8, we, bz, o, r);
    chk({tag, ":done"}, {63'd0, we}, 64'd1);
    chk({tag, ":busy_end"}, {63'd0, bz}, 64'd0);
    res = r;
    ov  = o;
  endtask

  initial begin
    logic [31:0] res, r, n, a, b, m;
    logic ov, we, bz;
    logic [1:0] mode;
    longint unsigned eres;
    bit eov;
    int cnt;

    drive(1'b0, 1'b0, 0, 0, 0, 0, 0);
    drive(1'b1, 1'b0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    smp(1'b0, we, bz, ov, r);
    chk("rst_we", {63'd0, we}, 0);
    chk("rst_busy", {63'd0, bz}, 0);
    chk("rst_ovf", {63'd0, ov}, 0);
    chk("rst_res", {32'd0, r}, 0);
    rst = 1'b0;

    run_job("fib10", 0, 10, 0, 1, 0, 0, res, ov);
    chk("fib10_res", {32'd0, res}, 55);
    chk("fib10_ovf", {63'd0, ov}, 0);

    run_job("n0", 0, 0, 7, 9, 0, 0, res, ov);
    chk("n0_res", {32'd0, res}, 7);

    // DONE holds its result while init_* wiggle
    repeat (3) begin
      @(negedge clk);
      drive(1'b0, 1'b0, $urandom, $urandom, $urandom, 2'($urandom), $urandom);
    end
    smp(1'b0, we, bz, ov, r);
    chk("hold_we", {63'd0, we}, 1);
    chk("hold_res", {32'd0, r}, 7);

    run_job("w8_wrap", 1, 14, 0, 1, 0, 0, res, ov);
    chk("w8_wrap_res", {32'd0, res}, 121);
    chk("w8_wrap_ovf", {63'd0, ov}, 1);
    run_job("w8_sat", 1, 14, 0, 1, 1, 0, res, ov);
    chk("w8_sat_res", {32'd0, res}, 255);
    chk("w8_sat_ovf", {63'd0, ov}, 1);

    run_job("mod10", 0, 10, 0, 1, 2, 10, res, ov);
    chk("mod10_res", {32'd0, res}, 5);
    chk("mod10_ovf", {63'd0, ov}, 0);
    run_job("mod0", 0, 10, 0, 1, 2, 0, res, ov);
    chk("mod0_res", {32'd0, res}, 55);

    // long job that overflows, aborted by a restart
    @(negedge clk);
    drive(1'b0, 1'b1, 1000, 32'hffff_ffff, 32'hffff_ffff, 0, 0);
    @(negedge clk);
    set_en(1'b0, 1'b0);
    cnt = 0;
    repeat (19) begin
      @(negedge clk);
      smp(1'b0, we, bz, ov, r);
      if (we) cnt++;
    end
    chk("abort_no_we", cnt, 0);
    chk("abort_ovf_set", {63'd0, ov}, 1);
    run_job("restart", 0, 5, 2, 3, 0, 0, res, ov);
    chk("restart_res", {32'd0, res}, 21);
    chk("restart_ovf", {63'd0, ov}, 0);

    // rst wins over a coincident r_enable
    @(negedge clk);
    drive(1'b0, 1'b1, 50, 1, 1, 0, 0);
    @(negedge clk);
    set_en(1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 1'b1, 3, 4, 5, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    set_en(1'b0, 1'b0);
    smp(1'b0, we, bz, ov, r);
    chk("rst_mid_we", {63'd0, we}, 0);
    chk("rst_mid_busy", {63'd0, bz}, 0);
    chk("rst_mid_res", {32'd0, r}, 0);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      smp(1'b0, we, bz, ov, r);
      if (we || bz) cnt++;
    end
    chk("rst_idle", cnt, 0);

    // r_enable held high keeps reloading
    @(negedge clk);
    drive(1'b0, 1'b1, 3, 1, 1, 0, 0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      smp(1'b0, we, bz, ov, r);
      if (we || !bz) cnt++;
    end
    chk("hold_en_run", cnt, 0);
    set_en(1'b0, 1'b0);
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      smp(1'b0, we, bz, ov, r);
      if (we) cnt++;
    end
    chk("hold_en_early", cnt, 0);
    @(negedge clk);
    smp(1'b0, we, bz, ov, r);
    chk("hold_en_we", {63'd0, we}, 1);
    chk("hold_en_res", {32'd0, r}, 3);

    for (int i = 0; i < 40; i++) begin
      bit w8;
      w8   = (i % 3) == 2;
      n    = $urandom_range(0, 40);
      mode = 2'($urandom_range(0, 3));
      if (w8) begin
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        m = $urandom_range(0, 255);
      end else begin
        a = $urandom;
        b = $urandom;
        m = $urandom;
        if ($urandom_range(0, 3) == 0) begin
          a = $urandom_range(0, 3);
          b = $urandom_range(0, 3);
        end
      end
      if (mode == 2'd2 && $urandom_range(0, 4) == 0) m = 0;
      if (mode == 2'd2 && m != 0) begin
        a = a % m;
        b = b % m;
      end
      ref_model(w8 ? 8 : 32, n, a, b, mode, m, eres, eov);
      run_job($sformatf("rnd%0d", i), w8, n, a, b, mode, m, res, ov);
      chk($sformatf("rnd%0d_res", i), {32'd0, res}, eres);
      chk($sformatf("rnd%0d_ovf", i), {63'd0, ov}, {63'd0, eov});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fib_seq_engine.md
Name: fib_seq_engine

Overview:
- Parametrised successor of the fixed 32-bit Fibonacci-step kernel.
- Starting from a load of (n, a, b), applies the step (a, b) <- (b, a+b) n times and returns the final a.
- Generalised in operand and count width. Adds three arithmetic modes (wrap, saturate, modular), a busy indication and a sticky overflow flag.
- Sits as a leaf compute unit behind the r_enable/w_enable start/done handshake used by the other generated kernels.

Parameters:
- WIDTH, 32, bit width of a, b, modulus and result.
- CNT_W, 32, bit width of the iteration count n.

Ports:
- clk  input  1  clock; all state changes on posedge clk.
- rst  input  1  synchronous active-high reset.
- r_enable  input  1  start strobe; loads all init_* inputs and (re)starts.
- init_n  input  CNT_W  iteration count (unsigned).
- init_a  input  WIDTH  initial a.
- init_b  input  WIDTH  initial b.
- init_mode  input  2  0=wrap, 1=saturate, 2=modular, 3=reserved (behaves as 0).
- init_mod  input  WIDTH  modulus for mode 2.
- w_enable  output  1  result valid (done).
- busy  output  1  iteration in progress.
- overflow  output  1  sticky: some sum exceeded 2^WIDTH-1 in mode 0/1.
- result  output  WIDTH  final a.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; w_enable=0, busy=0, overflow=0, result=0; internal a/b/cnt cleared. rst has priority over r_enable.
- States: IDLE, RUN, DONE.
- r_enable=1 at an edge (rst=0), in any state, including mid-RUN abort/restart:
  - latch a=init_a, b=init_b, cnt=init_n, mode, mod;
  - w_enable<=0, overflow<=0, busy<=1, state<=RUN.
- RUN, each edge:
  - if cnt==0: result<=a, w_enable<=1, busy<=0, state<=DONE;
  - else: a<=b, b<=f(a,b), cnt<=cnt-1.
- Latency: r_enable sampled at edge E0 gives w_enable=1 and a valid result after edge E0+n+1. One step per cycle, no stalls.
- DONE: w_enable and result held until next r_enable or rst. IDLE and DONE ignore init_* unless r_enable=1.
- f(a,b): sum s = a+b computed in WIDTH+1 bits.
  - Mode 0: f = s[WIDTH-1:0]; overflow<=1 if s[WIDTH]=1.
  - Mode 1: f = all-ones if s[WIDTH]=1, else s; overflow<=1 if s[WIDTH]=1.
  - Mode 2: f = s-mod if s>=mod, else s. Overflow never set.
  - Mode 2 requires init_a<mod and init_b<mod; out-of-range inputs give an unspecified value but the count/latency is unchanged. mod==0 in mode 2 behaves as mode 0 without setting overflow.
- overflow is updated only in RUN steps and is visible while busy. It is cleared only by rst or r_enable.
- r_enable held high continuously keeps reloading; state stays RUN with cnt=init_n.
- cnt wraps never: decrement only when cnt!=0.

Test Plan:
- WIDTH=32, n=10, a=0, b=1, mode 0 -> w_enable rises after edge E0+11; result=55; overflow=0; busy high for cycles E0+1..E0+11.
- n=0, a=7, b=9 -> w_enable after edge E0+1; result=7; busy for exactly one cycle.
- WIDTH=8, n=14, a=0, b=1:
  - mode 0 -> result=121 (377 mod 256), overflow=1;
  - mode 1 -> result=255, overflow=1.
- WIDTH=32, mode 2, mod=10, n=10, a=0, b=1 -> result=5, overflow=0. Same with mod=0 -> result=55.
- Start n=1000; pulse r_enable at cycle 20 with n=5, a=2, b=3 -> no w_enable from the first job; result=21 (2,3,5,8,13,21) after 6 cycles from restart edge; overflow cleared.
- rst asserted mid-RUN, coincident with r_enable -> next cycle: all outputs 0, state IDLE. No w_enable until a later r_enable.
